// File: rtl/secretkey_bram_arbiter_pkg.sv
// Shared constants and state encoding for the secret-key BRAM port-B arbiter.
// Sits alongside the PA parameter include.
package secretkey_bram_arbiter_pkg;

    localparam int SECRETKEY_ADDR_W    = 15;
    localparam int SECRETKEY_DATA_W    = 64;
    localparam int SECRETKEY_RD_LAT    = 2;
    localparam int SECRETKEY_BURST_MAX = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN_PA = 2'd1,
        OWN_RD = 2'd2
    } arb_state_t;

endpackage

// File: rtl/secretkey_rd_pipe.sv
// Read-return pipeline: carries a valid tag alongside the BRAM latency and registers
// doutb when the tag emerges. Reset flushes every in-flight tag.
module secretkey_rd_pipe
    import secretkey_bram_arbiter_pkg::*;
#(
    parameter int DATA_W = SECRETKEY_DATA_W,
    parameter int RD_LAT = SECRETKEY_RD_LAT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_fire,
    input  logic [DATA_W-1:0] bram_doutb,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    // tag[0] lines up with bram_enb; tag[RD_LAT] lines up with valid doutb.
    logic [RD_LAT:0] tag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag      <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            tag      <= {tag[RD_LAT-1:0], rd_fire};
            rd_valid <= tag[RD_LAT];
            if (tag[RD_LAT]) begin
                rd_data <= bram_doutb;
            end
        end
    end

endmodule

// File: rtl/secretkey_bram_arbiter.sv
// Arbitrates secret-key BRAM port B between PA writes and key-consumer reads.
// Optional wait-cycle statistics are built when SECRETKEY_ARB_STATS_EN is defined.
//
// state  | meaning
// IDLE   | no owner; PA has priority
// OWN_PA | PA engine owns the port
// OWN_RD | key consumer owns the port
module secretkey_bram_arbiter
    import secretkey_bram_arbiter_pkg::*;
#(
    parameter int ADDR_W    = SECRETKEY_ADDR_W,
    parameter int DATA_W    = SECRETKEY_DATA_W,
    parameter int RD_LAT    = SECRETKEY_RD_LAT,
    parameter int BURST_MAX = SECRETKEY_BURST_MAX
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pa_req,
    input  logic [ADDR_W-1:0]   pa_addr,
    input  logic [DATA_W-1:0]   pa_din,
    input  logic [DATA_W/8-1:0] pa_we,
    output logic                pa_gnt,
    input  logic                pa_finish,
    input  logic                rd_req,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                rd_gnt,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                rd_oob,
    input  logic                key_clear,
    output logic [ADDR_W:0]     key_words,
    output logic                key_ready,
    output logic [ADDR_W-1:0]   bram_addrb,
    output logic [DATA_W-1:0]   bram_dinb,
    input  logic [DATA_W-1:0]   bram_doutb,
    output logic                bram_enb,
    output logic [DATA_W/8-1:0] bram_web,
    output logic [31:0]         pa_wait_cnt,
    output logic [31:0]         rd_wait_cnt
);

    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [ADDR_W:0] KW_MAX = {1'b1, {ADDR_W{1'b0}}};

    arb_state_t      state, state_nxt;
    logic [BW-1:0]   burst_cnt, burst_nxt;
    logic            rd_eff;
    logic            burst_ok;
    logic            pa_xfer;
    logic            rd_xfer;

    assign rd_eff   = rd_req & key_ready;
    assign burst_ok = (burst_cnt < BW'(BURST_MAX));
    assign pa_xfer  = pa_req & pa_gnt;
    assign rd_xfer  = rd_req & rd_gnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_nxt;
        end
    end

    always_comb begin
        pa_gnt    = 1'b0;
        rd_gnt    = 1'b0;
        state_nxt = IDLE;
        burst_nxt = '0;

        // The owner keeps the port until its burst is spent while the other side waits.
        unique case (state)
            IDLE: begin
                pa_gnt = pa_req;
                rd_gnt = rd_eff & ~pa_req;
            end
            OWN_PA: begin
                if (pa_req && (burst_ok || !rd_eff)) begin
                    pa_gnt = 1'b1;
                end else begin
                    rd_gnt = rd_eff;
                end
            end
            OWN_RD: begin
                if (rd_eff && (burst_ok || !pa_req)) begin
                    rd_gnt = 1'b1;
                end else begin
                    pa_gnt = pa_req;
                end
            end
            default: begin
                pa_gnt = 1'b0;
                rd_gnt = 1'b0;
            end
        endcase

        if (pa_gnt) begin
            state_nxt = OWN_PA;
        end else if (rd_gnt) begin
            state_nxt = OWN_RD;
        end

        if (state_nxt == IDLE) begin
            burst_nxt = '0;
        end else if (state_nxt != state) begin
            burst_nxt = BW'(1);
        end else if (burst_ok) begin
            burst_nxt = burst_cnt + BW'(1);
        end else begin
            burst_nxt = burst_cnt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bram_enb   <= 1'b0;
            bram_addrb <= '0;
            bram_dinb  <= '0;
            bram_web   <= '0;
            rd_oob     <= 1'b0;
        end else begin
            bram_enb <= pa_xfer | rd_xfer;
            rd_oob   <= rd_xfer & ({1'b0, rd_addr} >= key_words);
            if (pa_xfer) begin
                bram_addrb <= pa_addr;
                bram_dinb  <= pa_din;
                bram_web   <= pa_we;
            end else if (rd_xfer) begin
                bram_addrb <= rd_addr;
                bram_dinb  <= '0;
                bram_web   <= '0;
            end else begin
                bram_addrb <= '0;
                bram_dinb  <= '0;
                bram_web   <= '0;
            end
        end
    end

    // A new key (key_clear) always wins over a same-cycle count or completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_words <= '0;
            key_ready <= 1'b0;
        end else begin
            if (key_clear) begin
                key_words <= '0;
            end else if (pa_xfer && (|pa_we) && (key_words < KW_MAX)) begin
                key_words <= key_words + 1'b1;
            end

            if (key_clear) begin
                key_ready <= 1'b0;
            end else if (pa_finish) begin
                key_ready <= 1'b1;
            end
        end
    end

    secretkey_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk        (clk),
        .reset      (reset),
        .rd_fire    (rd_xfer),
        .bram_doutb (bram_doutb),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid)
    );

`ifdef SECRETKEY_ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pa_wait_cnt <= '0;
            rd_wait_cnt <= '0;
        end else if (key_clear) begin
            pa_wait_cnt <= '0;
            rd_wait_cnt <= '0;
        end else begin
            if (pa_req && !pa_gnt && (pa_wait_cnt != 32'hFFFF_FFFF)) begin
                pa_wait_cnt <= pa_wait_cnt + 32'd1;
            end
            if (rd_eff && !rd_gnt && (rd_wait_cnt != 32'hFFFF_FFFF)) begin
                rd_wait_cnt <= rd_wait_cnt + 32'd1;
            end
        end
    end
`else
    assign pa_wait_cnt = '0;
    assign rd_wait_cnt = '0;
`endif

endmodule
